// File: rtl/memory_request.sv
// Data-memory request unit: turns execute-stage load/store requests into a registered
// bus handshake and stalls the pipeline until ack. Optional timeout: MEMREQ_TIMEOUT_EN.
module memory_request #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] memory_value,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic        req;
  logic        req_byte;
  logic        mis_c;
  logic        busy;
  logic        timeout_hit;
  logic [7:0]  lane_data;

  // A store wins over a load, so its byte flag decides alignment.
  always_comb begin
    req      = mem_read | mem_write;
    req_byte = mem_write ? store_byte : load_byte;
    mis_c    = req && !req_byte && (address[1:0] != 2'b00);
    busy     = (state == READ) || (state == WRITE);
  end

  assign misaligned = (state == IDLE) && mis_c;
  assign stall      = (state == IDLE) ? (req && !mis_c) : busy;
  assign lane_data  = bus_rdata[{lane_q, 3'b000} +: 8];

`ifdef MEMREQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  logic [CNT_W-1:0] cnt;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Held at zero outside a transaction so every READ/WRITE starts from a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      cnt       <= busy ? cnt + 1'b1 : '0;
      bus_error <= busy && !bus_ack && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0 && (TIMEOUT != 0);
  assign bus_error   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_q       <= 1'b0;
      lane_q       <= 2'b00;
      memory_value <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_byte_en  <= '0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !mis_c) begin
            bus_addr <= {address[31:2], 2'b00};
            lane_q   <= address[1:0];
            byte_q   <= req_byte;
            if (mem_write) begin
              state       <= WRITE;
              bus_write   <= 1'b1;
              bus_byte_en <= store_byte ? (4'b0001 << address[1:0]) : 4'b1111;
              bus_wdata   <= store_byte ? {4{store_data[7:0]}} : store_data;
            end else begin
              state       <= READ;
              bus_read    <= 1'b1;
              bus_byte_en <= 4'b1111;
            end
          end
        end
        READ: begin
          if (bus_ack) begin
            state        <= DONE;
            bus_read     <= 1'b0;
            memory_value <= byte_q ? {24'b0, lane_data} : bus_rdata;
          end else if (timeout_hit) begin
            state        <= DONE;
            bus_read     <= 1'b0;
            memory_value <= '0;
          end
        end
        WRITE: begin
          if (bus_ack || timeout_hit) begin
            state     <= DONE;
            bus_write <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
